// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and constants for the WS2812 frame arbiter
package ws2812_pkg;

    typedef enum logic [1:0] {
        MODE_SELECT = 2'b00,
        MODE_FIND   = 2'b01,
        MODE_DRAW   = 2'b10,
        MODE_NONE   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_FRAME = 2'b10,
        ST_LATCH = 2'b11
    } state_t;

    localparam int          LED_NUM_DEF = 64;
    localparam logic [23:0] BLACK       = 24'h000000;

    function automatic logic [2:0] mode_onehot(mode_t m);
        logic [2:0] oh;
        oh = 3'b000;
        case (m)
            MODE_SELECT: oh = 3'b001;
            MODE_FIND:   oh = 3'b010;
            MODE_DRAW:   oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ws2812_frame_arbiter_if.sv
// rtl/ws2812_frame_arbiter_if.sv - source/controller signal bundle around the frame arbiter
interface ws2812_frame_arbiter_if;
    import ws2812_pkg::*;

    mode_t       mode;
    logic [2:0]  req_start;
    logic [5:0]  cfg_num_0;
    logic [5:0]  cfg_num_1;
    logic [5:0]  cfg_num_2;
    logic [23:0] cfg_data_0;
    logic [23:0] cfg_data_1;
    logic [23:0] cfg_data_2;
    logic        cfg_start_in;
    logic        ws2812_start_out;
    logic [5:0]  cfg_num_out;
    logic [23:0] cfg_data_out;
    logic [2:0]  cfg_start_out;
    logic [2:0]  grant;
    mode_t       mode_active;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  mode, req_start, cfg_num_0, cfg_num_1, cfg_num_2,
               cfg_data_0, cfg_data_1, cfg_data_2, cfg_start_in,
        output ws2812_start_out, cfg_num_out, cfg_data_out, cfg_start_out,
               grant, mode_active, busy, timeout_err
    );

    modport master (
        output mode, req_start, cfg_num_0, cfg_num_1, cfg_num_2,
               cfg_data_0, cfg_data_1, cfg_data_2, cfg_start_in,
        input  ws2812_start_out, cfg_num_out, cfg_data_out, cfg_start_out,
               grant, mode_active, busy, timeout_err
    );

endinterface

// File: rtl/ws2812_cycle_timer.sv
// rtl/ws2812_cycle_timer.sv - loadable down-counter with terminal-count flag
module ws2812_cycle_timer #(
    parameter int CYC = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic tc_o
);

    localparam int W = $clog2(CYC) + 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Loading CYC-1 makes tc_o rise on the CYC-th decrementing cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CYC - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// rtl/ws2812_frame_arbiter.sv - frame-atomic scheduler sharing one ws2812_ctrl among three sources
module ws2812_frame_arbiter
    import ws2812_pkg::*;
#(
    parameter int LED_NUM     = LED_NUM_DEF,
    parameter int LATCH_CYC   = 15000,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    ws2812_frame_arbiter_if.slave  bus
);

    state_t     state_q;
    logic [2:0] grant_q;
    mode_t      mode_active_q;
    logic [6:0] pix_q;
    logic       timeout_err_q;

    logic active;
    logic last_pix;
    logic req_hit;
    logic latch_tc;
    logic tmo_tc;
    logic tmo_hit;

    assign active   = (state_q == ST_BLANK) || (state_q == ST_FRAME);
    assign last_pix = bus.cfg_start_in && (pix_q == 7'(LED_NUM - 1));
    assign req_hit  = (bus.mode != MODE_NONE) && ((mode_onehot(bus.mode) & bus.req_start) != 3'b000);
    // A pixel request on the terminal-count cycle keeps the frame alive.
    assign tmo_hit  = active && tmo_tc && !bus.cfg_start_in;

    ws2812_cycle_timer #(.CYC(LATCH_CYC)) u_latch_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load_i    (state_q != ST_LATCH),
        .dec_i     (state_q == ST_LATCH),
        .tc_o      (latch_tc)
    );

    ws2812_cycle_timer #(.CYC(TIMEOUT_CYC)) u_timeout_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load_i    (!active || bus.cfg_start_in),
        .dec_i     (active),
        .tc_o      (tmo_tc)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 3'b000;
            mode_active_q <= MODE_NONE;
            pix_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pix_q <= '0;
                    if (bus.mode != mode_active_q) begin
                        mode_active_q <= bus.mode;
                        state_q       <= (bus.mode == MODE_NONE) ? ST_IDLE : ST_BLANK;
                    end else if (req_hit) begin
                        grant_q <= mode_onehot(bus.mode);
                        state_q <= ST_FRAME;
                    end
                end
                ST_BLANK, ST_FRAME: begin
                    if (tmo_hit) begin
                        timeout_err_q <= 1'b1;
                        grant_q       <= 3'b000;
                        pix_q         <= '0;
                        state_q       <= ST_LATCH;
                    end else if (last_pix) begin
                        grant_q <= 3'b000;
                        pix_q   <= '0;
                        state_q <= ST_LATCH;
                    end else if (bus.cfg_start_in) begin
                        pix_q <= pix_q + 7'd1;
                    end
                end
                ST_LATCH: begin
                    pix_q <= '0;
                    if (latch_tc) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pixel path is combinational so ws2812_ctrl sees the source data in the request cycle.
    always_comb begin
        bus.cfg_num_out   = 6'd0;
        bus.cfg_data_out  = BLACK;
        bus.cfg_start_out = 3'b000;
        case (state_q)
            ST_BLANK: bus.cfg_num_out = pix_q[5:0];
            ST_FRAME: begin
                bus.cfg_start_out = grant_q & {3{bus.cfg_start_in}};
                case (grant_q)
                    3'b001: begin
                        bus.cfg_num_out  = bus.cfg_num_0;
                        bus.cfg_data_out = bus.cfg_data_0;
                    end
                    3'b010: begin
                        bus.cfg_num_out  = bus.cfg_num_1;
                        bus.cfg_data_out = bus.cfg_data_1;
                    end
                    3'b100: begin
                        bus.cfg_num_out  = bus.cfg_num_2;
                        bus.cfg_data_out = bus.cfg_data_2;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.ws2812_start_out = active;
    assign bus.grant            = grant_q;
    assign bus.mode_active      = mode_active_q;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// tb/tb_ws2812_frame_arbiter.sv - scoreboard bench for ws2812_frame_arbiter
module tb_ws2812_frame_arbiter;
    import ws2812_pkg::*;

    localparam int LED = 4;
    localparam int LC  = 20;
    localparam int TC  = 60;
    localparam int BUD = 3000;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    ws2812_frame_arbiter_if bus ();

    ws2812_frame_arbiter #(
        .LED_NUM     (LED),
        .LATCH_CYC   (LC),
        .TIMEOUT_CYC (TC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];
    bit    ctrl_en = 1'b1;
    bit    spur_en = 1'b0;
    bit    seen_high = 1'b0;
    int    cyc = 0, pop_cnt = 0, last_pulse_cyc = 0;
    int    te_cnt = 0, te_cyc = 0, low_run = 0, last_gap = -1;
    mode_t ma_m = MODE_NONE;
    logic [5:0]  num_s[3];
    logic [23:0] dat_s[3];

    task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_sources();
        for (int k = 0; k < 3; k++) begin
            num_s[k] = 6'($urandom_range(0, 63));
            dat_s[k] = 24'($urandom);
        end
        bus.cfg_num_0 = num_s[0]; bus.cfg_data_0 = dat_s[0];
        bus.cfg_num_1 = num_s[1]; bus.cfg_data_1 = dat_s[1];
        bus.cfg_num_2 = num_s[2]; bus.cfg_data_2 = dat_s[2];
    endtask

    // k = 3 pushes an all-black blanking frame; otherwise a frame from source k.
    task automatic push_frame(int k);
        logic [2:0] oh;
        for (int i = 0; i < LED; i++) begin
            if (k == 3) begin
                exp_q.push_back({3'b000, 3'b000, 6'(i), 24'h000000});
            end else begin
                oh = 3'(1 << k);
                exp_q.push_back({oh, oh, num_s[k], dat_s[k]});
            end
        end
    endtask

    task automatic wait_grant(logic [2:0] g);
        int n = 0;
        while (bus.grant !== g && n < BUD) begin @(negedge sys_clk); n++; end
        chk("wait_grant", {33'd0, bus.grant}, {33'd0, g});
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < BUD) begin @(negedge sys_clk); n++; end
        chk("drain_queue", 36'(exp_q.size()), 36'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < BUD) begin @(negedge sys_clk); n++; end
        chk("wait_idle", {35'd0, bus.busy}, 36'd0);
    endtask

    task automatic wait_pops(int target);
        int n = 0;
        while (pop_cnt < target && n < BUD) begin @(negedge sys_clk); n++; end
        chk("wait_pops", {35'd0, pop_cnt >= target}, 36'd1);
    endtask

    // Frame-level model: a new owner costs one blank frame, a held request costs one frame.
    task automatic run_round(mode_t m, logic [2:0] r);
        bit frame_exp;
        @(negedge sys_clk);
        if (m != ma_m) begin
            if (m != MODE_NONE) push_frame(3);
            ma_m = m;
        end
        frame_exp = (m != MODE_NONE) && (((r >> m) & 3'b001) != 3'b000);
        if (frame_exp) push_frame(int'(m));
        bus.mode      = m;
        bus.req_start = r;
        repeat (2) @(negedge sys_clk);
        if (frame_exp) begin
            wait_grant(3'(1 << m));
            bus.req_start = 3'b000;
        end
        wait_empty();
        wait_idle();
        chk("round_mode_active", {34'd0, bus.mode_active}, {34'd0, ma_m});
        chk("round_grant", {33'd0, bus.grant}, 36'd0);
    endtask

    initial begin
        bus.cfg_start_in = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            bus.cfg_start_in = (ctrl_en && bus.ws2812_start_out && ($urandom_range(0, 2) == 0))
                             || (spur_en && ($urandom_range(0, 1) == 0));
        end
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (bus.ws2812_start_out) begin
            if (seen_high && low_run > 0) begin
                last_gap = low_run;
                chk("latch_gap_min", {35'd0, last_gap >= LC}, 36'd1);
            end
            low_run   = 0;
            seen_high = 1'b1;
        end else begin
            low_run++;
        end
        if (bus.cfg_start_in) begin
            if (bus.ws2812_start_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", {bus.grant, bus.cfg_start_out, bus.cfg_num_out, bus.cfg_data_out}, 36'hFFFFFFFFF);
                end else begin
                    chk("pixel", {bus.grant, bus.cfg_start_out, bus.cfg_num_out, bus.cfg_data_out}, exp_q.pop_front());
                end
                pop_cnt++;
                last_pulse_cyc = cyc;
            end else begin
                chk("spurious_not_forwarded", {33'd0, bus.cfg_start_out}, 36'd0);
            end
        end
        if (bus.timeout_err) begin
            te_cnt++;
            te_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int te0, p0, dt;
        mode_t rm;
        bus.mode      = MODE_NONE;
        bus.req_start = 3'b000;
        set_sources();

        repeat (3) @(negedge sys_clk);
        chk("rst_start_out", {35'd0, bus.ws2812_start_out}, 36'd0);
        chk("rst_grant", {33'd0, bus.grant}, 36'd0);
        chk("rst_mode_active", {34'd0, bus.mode_active}, {34'd0, MODE_NONE});
        chk("rst_busy", {35'd0, bus.busy}, 36'd0);
        chk("rst_timeout_err", {35'd0, bus.timeout_err}, 36'd0);
        sys_rst_n = 1'b1;

        // blank after reset, then a source-0 frame after exactly one latch gap plus the IDLE cycle
        run_round(MODE_SELECT, 3'b001);
        chk("first_gap", 36'(last_gap), 36'(LC + 1));

        // owner switch 00 -> 10 after the 2nd pixel
        @(negedge sys_clk);
        push_frame(0);
        p0 = pop_cnt;
        bus.req_start = 3'b001;
        wait_pops(p0 + 2);
        bus.mode      = MODE_DRAW;
        bus.req_start = 3'b101;
        push_frame(3);
        push_frame(2);
        ma_m = MODE_DRAW;
        wait_grant(3'b100);
        bus.req_start = 3'b000;
        wait_empty();
        wait_idle();
        chk("switch_mode_active", {34'd0, bus.mode_active}, {34'd0, MODE_DRAW});

        // find with no request: blank only, then a one-cycle grant
        run_round(MODE_FIND, 3'b000);
        repeat (5) @(negedge sys_clk);
        chk("find_idle_busy", {35'd0, bus.busy}, 36'd0);
        push_frame(1);
        bus.req_start = 3'b010;
        @(posedge sys_clk);
        #2;
        chk("find_grant_1cyc", {33'd0, bus.grant}, 36'd2);
        @(negedge sys_clk);
        bus.req_start = 3'b000;
        wait_empty();
        wait_idle();

        // controller stalls mid-frame
        @(negedge sys_clk);
        push_frame(1);
        p0  = pop_cnt;
        te0 = te_cnt;
        bus.req_start = 3'b010;
        wait_pops(p0 + 2);
        ctrl_en       = 1'b0;
        bus.req_start = 3'b000;
        begin
            int n = 0;
            while (te_cnt == te0 && n < BUD) begin @(negedge sys_clk); n++; end
        end
        dt = te_cyc - last_pulse_cyc;
        chk("timeout_seen", 36'(te_cnt - te0), 36'd1);
        chk("timeout_cycles", {35'd0, (dt == TC) || (dt == TC + 1)}, 36'd1);
        chk("timeout_grant", {33'd0, bus.grant}, 36'd0);
        chk("timeout_in_latch", {35'd0, bus.busy & ~bus.ws2812_start_out}, 36'd1);
        chk("timeout_mode_active", {34'd0, bus.mode_active}, {34'd0, MODE_FIND});
        exp_q.delete();
        repeat (5) @(negedge sys_clk);
        chk("timeout_once", 36'(te_cnt - te0), 36'd1);
        ctrl_en = 1'b1;
        wait_idle();

        // release the strip: no blank, spurious requests never forwarded
        @(negedge sys_clk);
        bus.mode      = MODE_DRAW;
        bus.req_start = 3'b100;
        push_frame(3);
        push_frame(2);
        ma_m = MODE_DRAW;
        wait_grant(3'b100);
        bus.mode      = MODE_NONE;
        bus.req_start = 3'b000;
        ma_m = MODE_NONE;
        wait_empty();
        spur_en = 1'b1;
        wait_idle();
        repeat (LC) @(negedge sys_clk);
        spur_en = 1'b0;
        chk("none_mode_active", {34'd0, bus.mode_active}, {34'd0, MODE_NONE});
        chk("none_busy", {35'd0, bus.busy}, 36'd0);
        chk("none_grant", {33'd0, bus.grant}, 36'd0);

        // asynchronous reset mid-frame
        @(negedge sys_clk);
        bus.mode      = MODE_SELECT;
        bus.req_start = 3'b001;
        push_frame(3);
        push_frame(0);
        ma_m = MODE_SELECT;
        wait_grant(3'b001);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_start_out", {35'd0, bus.ws2812_start_out}, 36'd0);
        chk("arst_grant", {33'd0, bus.grant}, 36'd0);
        chk("arst_busy", {35'd0, bus.busy}, 36'd0);
        exp_q.delete();
        seen_high     = 1'b0;
        low_run       = 0;
        ma_m          = MODE_NONE;
        bus.mode      = MODE_NONE;
        bus.req_start = 3'b000;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_round(MODE_SELECT, 3'b001);

        // randomized rounds against the frame-level model
        for (int i = 0; i < 10; i++) begin
            set_sources();
            rm = mode_t'($urandom_range(0, 3));
            run_round(rm, 3'($urandom_range(0, 7)));
        end

        repeat (5) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_arbiter.md
Name: ws2812_frame_arbiter

Overview:
- Shares the single ws2812_ctrl serializer between the three frame sources: select (menu), find and draw.
- Replaces a free-running combinational mode mux with a frame-atomic scheduler. Ownership changes only between frames, never mid-frame.
- On every ownership change, sends one all-black blanking frame and enforces the WS2812 latch gap between frames.
- Sits between the three source blocks and ws2812_ctrl inside ws2812_top.

Parameters:
- LED_NUM, 64: pixels per frame, range 1..64.
- LATCH_CYC, 15000: idle cycles after each frame (300 us at 50 MHz).
- TIMEOUT_CYC, 50000: longest gap between cfg_start_in pulses inside a frame before the frame is aborted.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- mode  in  2  requested owner: 00 select, 01 find, 10 draw, 11 none
- req_start  in  3  ws2812_start from sources; bit0 select, bit1 find, bit2 draw
- cfg_num_0/1/2  in  6  pixel index from select/find/draw
- cfg_data_0/1/2  in  24  GRB pixel data from select/find/draw
- cfg_start_in  in  1  per-pixel data request pulse from ws2812_ctrl
- ws2812_start_out  out  1  frame-enable level to ws2812_ctrl
- cfg_num_out  out  6  pixel index to ws2812_ctrl
- cfg_data_out  out  24  pixel data to ws2812_ctrl
- cfg_start_out  out  3  cfg_start_in routed to the granted source only
- grant  out  3  one-hot current owner, 000 = none
- mode_active  out  2  mode currently owning the strip
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Clock and reset: sys_clk; sys_rst_n asynchronous, active-low.
- Reset values: state IDLE, grant 000, mode_active 11, ws2812_start_out 0, busy 0, timeout_err 0, pixel counter 0, latch/timeout counters 0.
  - Because mode_active resets to 11, the first non-11 mode after reset always produces a blank frame.
- States:
  - IDLE
  - BLANK: all-black frame
  - FRAME: granted source owns the controller
  - LATCH: inter-frame gap
- Mode-to-index map: 00→0, 01→1, 10→2.
- IDLE transitions, evaluated each cycle:
  - mode != mode_active: go to BLANK and load mode_active <= mode. If mode = 11, go straight to IDLE and set mode_active 11 without blanking.
  - Otherwise, mode != 11 and req_start[idx(mode)] = 1: set grant = onehot(idx) and go to FRAME.
  - Otherwise stay in IDLE.
- BLANK:
  - ws2812_start_out = 1, cfg_data_out = 0, cfg_num_out = pixel counter.
  - Counter increments on each cfg_start_in.
  - After the LED_NUM-th pulse, go to LATCH.
  - cfg_start_out = 000 and grant = 000 throughout.
- FRAME:
  - ws2812_start_out = 1.
  - cfg_num_out / cfg_data_out are a combinational mux of the granted source.
  - cfg_start_out[idx] = cfg_start_in with zero latency; the other bits are 0.
  - Pixel counter counts cfg_start_in pulses. After the LED_NUM-th pulse, go to LATCH and clear grant on the same edge.
  - req_start dropping mid-frame is ignored; the frame always completes.
- LATCH:
  - ws2812_start_out = 0, outputs muxed to 0.
  - Count LATCH_CYC cycles, then go to IDLE.
  - cfg_start_in arriving in LATCH or IDLE is ignored and not forwarded.
- Mode changes during BLANK, FRAME or LATCH are deferred. Only the mode value present in IDLE is acted on; intermediate values are lost.
- Timeout:
  - In BLANK or FRAME, the timeout counter resets on each cfg_start_in.
  - If it reaches TIMEOUT_CYC: timeout_err pulses for 1 cycle, grant clears, state goes to LATCH. mode_active is unchanged.
- Simultaneous events:
  - cfg_start_in on the same cycle as the timeout terminal count: the pulse wins and the counter resets.
  - The last pixel pulse on the same cycle as a mode change: the frame completes, and the mode change is taken in the next IDLE.
- Counters: pixel counter 7 bit; latch/timeout counters sized $clog2 of their parameter + 1. No wrap-around is reachable, because every counter is cleared on state entry.
- Reset mid-operation returns everything to reset values immediately. Outputs are combinational from registered state/grant, so ws2812_start_out drops asynchronously.

Decomposition:
- Shared package ws2812_pkg holds:
  - MODE_SELECT = 2'b00, MODE_FIND = 2'b01, MODE_DRAW = 2'b10, MODE_NONE = 2'b11
  - the state encoding
  - the LED_NUM default and the BLACK = 24'h000000 constant
- One natural sub-module: ws2812_cycle_timer, a loadable down-counter with a terminal-count flag. It is instantiated twice: for the latch gap and for the timeout.

Test Plan:
- Reset release, mode=00, req_start=001, LED_NUM=4, ctrl model pulsing cfg_start_in → 4-pixel BLANK (cfg_data_out=0, cfg_num_out 0..3), then LATCH_CYC cycles of ws2812_start_out=0, then FRAME with grant=001 and cfg_data_out=cfg_data_0.
- mode 00→10 after the 2nd pixel of a FRAME → frame completes 4 pixels from source 0, then LATCH, then BLANK, then FRAME with grant=100; cfg_start_out[0] never pulses after the switch.
- mode=01 but req_start=000 → stays IDLE after the blank; busy=0. Raising req_start[1] → FRAME within 1 cycle, grant=010.
- Ctrl model stops pulsing mid-FRAME → timeout_err pulses exactly once at TIMEOUT_CYC, grant=000, LATCH entered, mode_active unchanged.
- mode=11 while strip owned by mode 10 → after the current frame and LATCH, returns to IDLE with mode_active=11, grant=000 and no blank frame; spurious cfg_start_in are not forwarded.
- sys_rst_n asserted mid-FRAME → ws2812_start_out, grant and busy go to 0 immediately. After release, the next frame is a BLANK frame.
